// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel coordinates and timing lock from hsync/vsync; define VGA_DECODER_ERRCOUNT_EN to build errorCount
module vga_sync_decoder #(
  parameter int Width = 640,
  parameter int Height = 480,
  parameter int LeftBorder = 48,
  parameter int RightBorder = 16,
  parameter int TopBorder = 33,
  parameter int BottomBorder = 10,
  parameter int HSyncPulse = 96,
  parameter int VSyncPulse = 2,
  parameter int SyncActiveLow = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       horizontalSync,
  input  logic                       verticalSync,
  output logic [$clog2(Width)-1:0]   column,
  output logic [$clog2(Height)-1:0]  line,
  output logic                       active,
  output logic                       frameStart,
  output logic                       locked,
  output logic                       timingError,
  output logic [7:0]                 errorCount
);
  localparam int HTotal = HSyncPulse + LeftBorder + Width + RightBorder;
  localparam int VTotal = VSyncPulse + TopBorder + Height + BottomBorder;
  localparam int HW = $clog2(HTotal);
  localparam int VW = $clog2(VTotal);
  localparam int PW = $clog2(HTotal + 1);
  localparam int CW = $clog2(Width);
  localparam int LW = $clog2(Height);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t state, state_nx;
  logic hp, hp_d, vp, vp_d, vpend, bad;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt, vlen;
  logic [PW-1:0] hlen, hper;
  logic h_lead, h_trail, v_lead, v_trail, vclr, h_fail, v_fail, fail, pix;
  assign h_lead = hp & ~hp_d;
  assign h_trail = ~hp & hp_d;
  assign v_lead = vp & ~vp_d;
  assign v_trail = ~vp & vp_d;
  assign vclr = h_trail & (vpend | v_trail);
  assign h_fail = (h_trail && hlen != PW'(HSyncPulse)) || (h_lead && hper != PW'(HTotal)) ||
                  (hcnt == HW'(HTotal - 1) && !h_trail);
  assign v_fail = (v_trail && (vlen != VW'(VSyncPulse) || vcnt != VW'(VTotal - 1))) ||
                  (h_trail && !vclr && vcnt == VW'(VTotal - 1));
  assign fail = h_fail | v_fail;
  assign pix = hcnt >= HW'(LeftBorder) && hcnt < HW'(LeftBorder + Width) &&
               vcnt >= VW'(TopBorder) && vcnt < VW'(TopBorder + Height) && state == LOCKED;
  // register syncs once as active-high pulses, keeping one more sample for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      {hp, hp_d, vp, vp_d} <= '0;
    end else begin
      hp <= (SyncActiveLow != 0) ? ~horizontalSync : horizontalSync;
      vp <= (SyncActiveLow != 0) ? ~verticalSync : verticalSync;
      hp_d <= hp;
      vp_d <= vp;
    end
  end
  // position counters plus pulse length and period measurements, all saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
      vpend <= 1'b0;
      hlen <= '0;
      hper <= '0;
      vlen <= '0;
    end else begin
      hcnt <= h_trail ? '0 : (hcnt == HW'(HTotal - 1)) ? hcnt : hcnt + 1'b1;
      vcnt <= vclr ? '0 : (h_trail && vcnt != VW'(VTotal - 1)) ? vcnt + 1'b1 : vcnt;
      vpend <= (v_trail && !h_trail) ? 1'b1 : h_trail ? 1'b0 : vpend;
      hlen <= h_lead ? PW'(1) : (hp && hlen != '1) ? hlen + 1'b1 : hlen;
      hper <= h_lead ? PW'(1) : (hper != '1) ? hper + 1'b1 : hper;
      vlen <= v_lead ? '0 : (vp && h_trail && vlen != '1) ? vlen + 1'b1 : vlen;
    end
  end
  // lock state register and per-frame failure flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEARCH;
      bad <= 1'b0;
    end else begin
      state <= state_nx;
      bad <= v_trail ? 1'b0 : (state == ACQUIRE && fail) ? 1'b1 : bad;
    end
  end
  // lock transitions: a clean frame between two vsync trailing edges is required to lock
  always_comb begin
    state_nx = state;
    state_nx = (state == SEARCH)  ? (v_trail ? ACQUIRE : SEARCH) :
               (state == ACQUIRE) ? ((v_trail && !(bad || fail)) ? LOCKED : ACQUIRE) :
                                    (fail ? SEARCH : LOCKED);
  end
  // registered coordinate, qualifier and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      column <= '0;
      line <= '0;
      active <= 1'b0;
      frameStart <= 1'b0;
      locked <= 1'b0;
      timingError <= 1'b0;
    end else begin
      column <= pix ? CW'(hcnt - HW'(LeftBorder)) : '0;
      line <= pix ? LW'(vcnt - VW'(TopBorder)) : '0;
      active <= pix;
      frameStart <= pix && hcnt == HW'(LeftBorder) && vcnt == VW'(TopBorder);
      locked <= state == LOCKED;
      timingError <= state == LOCKED && fail;
    end
  end
`ifdef VGA_DECODER_ERRCOUNT_EN
  // count timing errors, holding at 255
  always_ff @(posedge clk) begin
    if (rst) errorCount <= '0;
    else if (timingError && errorCount != 8'hff) errorCount <= errorCount + 1'b1;
  end
`else
  assign errorCount = '0;
`endif
endmodule
